// File: rtl/ps2_kb_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_kb_cmd_ctrl
//   Host-to-keyboard command sequencer for a PS/2 keyboard. Sends either the
//   keyboard reset command (FF, then waits for the self-test result) or the
//   set-LEDs command (ED followed by the LED argument byte). It handles
//   ACK/RESEND replies with a bounded retry count and a per-byte response
//   timeout. Receiver bytes that are not part of the command handshake are
//   forwarded to the scan-code path.
//
// Parameters
//   TIMEOUT_CYC : cycles to wait for each keyboard response byte
//   MAX_RETRY   : maximum resends of one byte after an FE reply
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   led_req      in   one-cycle request to send the LED state
//   led_val[2:0] in   {caps, num, scroll}, sampled when led_req is accepted
//   rst_req      in   one-cycle request to send the keyboard reset command
//   tx_idle      in   PS/2 transmitter ready for a byte
//   tx_wr        out  one-cycle strobe loading tx_data into the transmitter
//   tx_data[7:0] out  byte to transmit (holds the last byte sent)
//   rx_done_tick in   received-byte strobe
//   rx_data[7:0] in   received byte, valid with rx_done_tick
//   rx_fwd_tick  out  rx_done_tick minus the bytes consumed by the handshake
//   busy         out  high while a command is in progress
//   done_tick    out  one-cycle pulse on successful completion
//   err          out  sticky failure flag, cleared by the next accepted request
// ---------------------------------------------------------------------------
module ps2_kb_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       rst_req,
  input  logic       tx_idle,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_fwd_tick,
  output logic       busy,
  output logic       done_tick,
  output logic       err
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_LEDS  = 8'hED;
  localparam logic [7:0] RSP_ACK   = 8'hFA;
  localparam logic [7:0] RSP_RESND = 8'hFE;
  localparam logic [7:0] RSP_BATOK = 8'hAA;
  localparam logic [7:0] RSP_BATER = 8'hFC;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_BAT} state_t;

  state_t          state_reg;
  logic            byte_ptr_reg;   // 0: command byte, 1: argument byte
  logic            cmd_rst_reg;    // 1: reset command in flight, 0: LED command
  logic [7:0]      arg_reg;
  logic [RT_W-1:0] retry_reg;
  logic [TO_W-1:0] to_cnt_reg;

  logic [7:0]      cur_byte;
  logic [TO_W-1:0] to_cnt_next;
  logic            rx_ack, rx_resend, rx_bat_ok, rx_bat_err;
  logic            consumed;

  assign cur_byte = byte_ptr_reg ? arg_reg : (cmd_rst_reg ? CMD_RESET : CMD_LEDS);

  // Saturating increment: the counter never wraps even if the exit
  // compare were ever bypassed.
  assign to_cnt_next = (to_cnt_reg == {TO_W{1'b1}}) ? to_cnt_reg : to_cnt_reg + 1'b1;

  assign rx_ack     = rx_done_tick && (rx_data == RSP_ACK);
  assign rx_resend  = rx_done_tick && (rx_data == RSP_RESND);
  assign rx_bat_ok  = rx_done_tick && (rx_data == RSP_BATOK);
  assign rx_bat_err = rx_done_tick && (rx_data == RSP_BATER);

  // Only the handshake bytes the current wait state acts on are swallowed;
  // everything else (including bytes in IDLE/SEND) goes to the scan-code path.
  always_comb begin
    consumed = 1'b0;
    case (state_reg)
      WAIT_ACK: consumed = rx_ack || rx_resend;
      WAIT_BAT: consumed = rx_bat_ok || rx_bat_err;
      default:  consumed = 1'b0;
    endcase
  end

  assign rx_fwd_tick = rx_done_tick && !consumed;
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      byte_ptr_reg <= 1'b0;
      cmd_rst_reg  <= 1'b0;
      arg_reg      <= 8'h00;
      retry_reg    <= '0;
      to_cnt_reg   <= '0;
      tx_wr        <= 1'b0;
      tx_data      <= 8'h00;
      done_tick    <= 1'b0;
      err          <= 1'b0;
    end else begin
      tx_wr     <= 1'b0;
      done_tick <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Reset command wins when both requests arrive together.
          if (rst_req) begin
            cmd_rst_reg  <= 1'b1;
            byte_ptr_reg <= 1'b0;
            retry_reg    <= '0;
            err          <= 1'b0;
            state_reg    <= SEND;
          end else if (led_req) begin
            cmd_rst_reg  <= 1'b0;
            arg_reg      <= {5'b00000, led_val};
            byte_ptr_reg <= 1'b0;
            retry_reg    <= '0;
            err          <= 1'b0;
            state_reg    <= SEND;
          end
        end

        SEND: begin
          if (tx_idle) begin
            tx_wr      <= 1'b1;
            tx_data    <= cur_byte;
            to_cnt_reg <= '0;
            state_reg  <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (rx_ack) begin
            retry_reg <= '0;
            if (!cmd_rst_reg && !byte_ptr_reg) begin
              byte_ptr_reg <= 1'b1;
              state_reg    <= SEND;
            end else if (cmd_rst_reg) begin
              to_cnt_reg <= '0;
              state_reg  <= WAIT_BAT;
            end else begin
              done_tick <= 1'b1;
              state_reg <= IDLE;
            end
          end else if (rx_resend) begin
            if (retry_reg == RT_MAX) begin
              err       <= 1'b1;
              state_reg <= IDLE;
            end else begin
              retry_reg <= retry_reg + 1'b1;
              state_reg <= SEND;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            err       <= 1'b1;
            state_reg <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_next;
          end
        end

        WAIT_BAT: begin
          if (rx_bat_ok) begin
            done_tick <= 1'b1;
            state_reg <= IDLE;
          end else if (rx_bat_err) begin
            err       <= 1'b1;
            state_reg <= IDLE;
          end else if (to_cnt_reg == TO_LAST) begin
            err       <= 1'b1;
            state_reg <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_next;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kb_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_kb_cmd_ctrl
//   Table of directed command/reply scenarios, hand-written sequences for
//   reset, transmitter stall, exact timeout and mid-command reset, then
//   random commands checked against a transaction-level keyboard model.
// ---------------------------------------------------------------------------
module tb_ps2_kb_cmd_ctrl;

  localparam int TO = 100;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       rst_req = 1'b0;
  logic       tx_idle = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_wr, rx_fwd_tick, busy, done_tick, err;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  ps2_kb_cmd_ctrl #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .led_req(led_req), .led_val(led_val),
    .rst_req(rst_req), .tx_idle(tx_idle), .tx_wr(tx_wr), .tx_data(tx_data),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data), .rx_fwd_tick(rx_fwd_tick),
    .busy(busy), .done_tick(done_tick), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_log[$];
  int         done_cnt = 0;
  logic [7:0] reply_q[$];
  bit         fwd_obs[$];
  logic [7:0] exp_tx_q[$];
  bit         exp_fwd_q[$];
  bit         exp_active_q[$];
  int         exp_done;
  int         exp_err;

  // Record transmitted bytes and completion pulses, sampled mid-cycle.
  always @(posedge clk) begin
    #2;
    if (tx_wr === 1'b1) tx_log.push_back(tx_data);
    if (done_tick === 1'b1) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Keyboard-level reference: walks the reply list against the command's
  // byte list, counting transmissions of the current byte.
  function automatic void model(input bit is_rst, input logic [2:0] val);
    logic [7:0] seq [2];
    int len, pos, sent;
    bit active, in_bat, used;
    exp_tx_q.delete(); exp_fwd_q.delete(); exp_active_q.delete();
    exp_done = 0; exp_err = 0;
    seq[0] = is_rst ? 8'hFF : 8'hED;
    seq[1] = {5'b00000, val};
    len = is_rst ? 1 : 2;
    pos = 0; sent = 1; active = 1; in_bat = 0;
    exp_tx_q.push_back(seq[0]);
    foreach (reply_q[i]) begin
      logic [7:0] r;
      r = reply_q[i];
      exp_active_q.push_back(active);
      used = active && (in_bat ? (r == 8'hAA || r == 8'hFC) : (r == 8'hFA || r == 8'hFE));
      exp_fwd_q.push_back(!used);
      if (used) begin
        if (in_bat) begin
          if (r == 8'hAA) exp_done = 1; else exp_err = 1;
          active = 0;
        end else if (r == 8'hFA) begin
          pos++;
          if (pos < len) begin
            exp_tx_q.push_back(seq[pos]);
            sent = 1;
          end else if (is_rst) begin
            in_bat = 1;
          end else begin
            exp_done = 1;
            active = 0;
          end
        end else if (sent == MR + 1) begin
          exp_err = 1;
          active = 0;
        end else begin
          sent++;
          exp_tx_q.push_back(seq[pos]);
        end
      end
    end
    if (active) exp_err = 1;  // no decisive reply left: timeout
  endfunction

  function automatic logic [7:0] pick_reply();
    int k;
    logic [7:0] b;
    k = $urandom_range(0, 99);
    if (k < 40) return 8'hFA;
    if (k < 60) return 8'hFE;
    if (k < 75) return 8'hAA;
    if (k < 80) return 8'hFC;
    b = 8'($urandom);
    while (b == 8'hFA || b == 8'hFE || b == 8'hAA || b == 8'hFC) b = 8'($urandom);
    return b;
  endfunction

  task automatic start_txn();
    tx_log.delete();
    fwd_obs.delete();
    done_cnt = 0;
  endtask

  task automatic issue_req(input bit r, input bit l, input logic [2:0] v);
    @(negedge clk);
    rst_req = r; led_req = l; led_val = v;
    @(negedge clk);
    rst_req = 1'b0; led_req = 1'b0; led_val = 3'($urandom);
    chk("accept_busy", int'(busy), 1);
    chk("accept_err_clear", int'(err), 0);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_reached", int'(busy), 0);
    @(negedge clk);
  endtask

  task automatic feed_replies(input bit spurious);
    for (int i = 0; i < reply_q.size(); i++) begin
      repeat (3) @(negedge clk);
      rx_done_tick = 1'b1;
      rx_data = reply_q[i];
      if (spurious && exp_active_q[i]) begin
        led_req = 1'b1;
        rst_req = 1'($urandom_range(0, 1));
        led_val = 3'($urandom);
      end
      #1 fwd_obs.push_back(rx_fwd_tick);
      @(negedge clk);
      rx_done_tick = 1'b0; rx_data = 8'($urandom);
      led_req = 1'b0; rst_req = 1'b0;
    end
    wait_idle();
  endtask

  task automatic compare(input string tag);
    chk({tag, " tx_count"}, tx_log.size(), exp_tx_q.size());
    for (int i = 0; i < tx_log.size() && i < exp_tx_q.size(); i++)
      chk($sformatf("%s tx_byte%0d", tag, i), int'(tx_log[i]), int'(exp_tx_q[i]));
    chk({tag, " fwd_count"}, fwd_obs.size(), exp_fwd_q.size());
    for (int i = 0; i < fwd_obs.size() && i < exp_fwd_q.size(); i++)
      chk($sformatf("%s fwd%0d", tag, i), int'(fwd_obs[i]), int'(exp_fwd_q[i]));
    chk({tag, " done_cnt"}, done_cnt, exp_done);
    chk({tag, " err"}, int'(err), exp_err);
    $display("[TB] %s: cmd bytes=%0d replies=%0d done=%0d err=%0d", tag,
             tx_log.size(), fwd_obs.size(), done_cnt, err);
  endtask

  // Directed table: request, reply bytes (read left to right), expected
  // transmitted bytes (left to right), forward flag per reply (MSB first).
  typedef struct packed {
    logic        do_rst;
    logic        do_led;
    logic [2:0]  val;
    logic [3:0]  nrep;
    logic [47:0] rep;
    logic [3:0]  ntx;
    logic [47:0] tx;
    logic [5:0]  fwd;
    logic        done;
    logic        err;
  } vec_t;

  function automatic vec_t mkv(input bit r, input bit l, input logic [2:0] v,
                               input int nr, input logic [47:0] rp,
                               input int nt, input logic [47:0] tp,
                               input logic [5:0] f, input bit d, input bit e);
    vec_t x;
    x.do_rst = r; x.do_led = l; x.val = v;
    x.nrep = 4'(nr); x.rep = rp; x.ntx = 4'(nt); x.tx = tp;
    x.fwd = f; x.done = d; x.err = e;
    return x;
  endfunction

  vec_t vecs [11];

  initial begin
    vec_t cur;
    logic [47:0] rp, tp;

    vecs[0]  = mkv(0, 1, 3'b101, 2, 48'hFA_FA_00_00_00_00, 2, 48'hED_05_00_00_00_00, 6'b000000, 1, 0);
    vecs[1]  = mkv(0, 1, 3'b101, 3, 48'hFE_FA_FA_00_00_00, 3, 48'hED_ED_05_00_00_00, 6'b000000, 1, 0);
    vecs[2]  = mkv(0, 1, 3'b101, 4, 48'hFE_FE_FE_FE_00_00, 4, 48'hED_ED_ED_ED_00_00, 6'b000000, 0, 1);
    vecs[3]  = mkv(1, 0, 3'b000, 2, 48'hFA_AA_00_00_00_00, 1, 48'hFF_00_00_00_00_00, 6'b000000, 1, 0);
    vecs[4]  = mkv(1, 0, 3'b000, 2, 48'hFA_FC_00_00_00_00, 1, 48'hFF_00_00_00_00_00, 6'b000000, 0, 1);
    vecs[5]  = mkv(1, 1, 3'b010, 0, 48'h00_00_00_00_00_00, 1, 48'hFF_00_00_00_00_00, 6'b000000, 0, 1);
    vecs[6]  = mkv(0, 1, 3'b010, 2, 48'hFA_FA_00_00_00_00, 2, 48'hED_02_00_00_00_00, 6'b000000, 1, 0);
    vecs[7]  = mkv(0, 1, 3'b111, 3, 48'hFA_1C_FA_00_00_00, 2, 48'hED_07_00_00_00_00, 6'b010000, 1, 0);
    vecs[8]  = mkv(1, 0, 3'b000, 4, 48'hFE_FA_1C_AA_00_00, 2, 48'hFF_FF_00_00_00_00, 6'b001000, 1, 0);
    vecs[9]  = mkv(0, 1, 3'b000, 1, 48'hFA_00_00_00_00_00, 2, 48'hED_00_00_00_00_00, 6'b000000, 0, 1);
    vecs[10] = mkv(0, 1, 3'b011, 3, 48'hFA_FA_1C_00_00_00, 2, 48'hED_03_00_00_00_00, 6'b001000, 1, 0);

    // Reset state, then a request on the very first edge after release.
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_wr", int'(tx_wr), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_done", int'(done_tick), 0);
    chk("rst_err", int'(err), 0);
    start_txn();
    @(negedge clk);
    reset = 1'b1; led_req = 1'b1; led_val = 3'b101;
    @(negedge clk);
    led_req = 1'b0;
    chk("first_edge_accept", int'(busy), 1);
    reply_q.delete(); reply_q.push_back(8'hFA); reply_q.push_back(8'hFA);
    exp_tx_q.delete(); exp_tx_q.push_back(8'hED); exp_tx_q.push_back(8'h05);
    exp_fwd_q.delete(); exp_fwd_q.push_back(1'b0); exp_fwd_q.push_back(1'b0);
    exp_done = 1; exp_err = 0;
    feed_replies(0);
    compare("first_req");
    repeat (4) @(negedge clk);
    chk("tx_data_hold", int'(tx_data), 8'h05);

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      cur = vecs[v];
      rp = cur.rep;
      tp = cur.tx;
      reply_q.delete(); exp_tx_q.delete(); exp_fwd_q.delete();
      for (int i = 0; i < int'(cur.nrep); i++) begin
        reply_q.push_back(rp[47-8*i -: 8]);
        exp_fwd_q.push_back(cur.fwd[5-i]);
      end
      for (int i = 0; i < int'(cur.ntx); i++) exp_tx_q.push_back(tp[47-8*i -: 8]);
      exp_done = int'(cur.done);
      exp_err  = int'(cur.err);
      start_txn();
      issue_req(cur.do_rst, cur.do_led, cur.val);
      feed_replies(0);
      compare($sformatf("vec%0d", v));
    end

    // Transmitter stall: nothing sent until tx_idle rises.
    start_txn();
    tx_idle = 1'b0;
    issue_req(0, 1, 3'b110);
    repeat (5) @(negedge clk);
    chk("stall_no_wr", tx_log.size(), 0);
    chk("stall_busy", int'(busy), 1);
    tx_idle = 1'b1;
    @(negedge clk);
    chk("stall_wr", int'(tx_wr), 1);
    chk("stall_data", int'(tx_data), 8'hED);
    reply_q.delete(); reply_q.push_back(8'hFA); reply_q.push_back(8'hFA);
    exp_tx_q.delete(); exp_tx_q.push_back(8'hED); exp_tx_q.push_back(8'h06);
    exp_fwd_q.delete(); exp_fwd_q.push_back(1'b0); exp_fwd_q.push_back(1'b0);
    exp_done = 1; exp_err = 0;
    feed_replies(0);
    compare("stall");

    // Exact timeout: err rises TO cycles after the strobe cycle.
    start_txn();
    issue_req(1, 0, 3'b000);
    for (int k = 0; k < 10 && !tx_wr; k++) @(negedge clk);
    chk("to_wr_seen", int'(tx_wr), 1);
    repeat (TO - 1) @(negedge clk);
    chk("to_busy_before", int'(busy), 1);
    chk("to_err_before", int'(err), 0);
    @(negedge clk);
    chk("to_busy_after", int'(busy), 0);
    chk("to_err_after", int'(err), 1);
    chk("to_no_done", done_cnt, 0);

    // Asynchronous reset while stuck in SEND.
    start_txn();
    tx_idle = 1'b0;
    issue_req(0, 1, 3'b101);
    @(negedge clk);
    chk("ar_pre_data", int'(tx_data), 8'hFF);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_tx_wr", int'(tx_wr), 0);
    chk("ar_tx_data", int'(tx_data), 0);
    chk("ar_err", int'(err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; tx_idle = 1'b1;

    // Asynchronous reset during the strobe cycle.
    start_txn();
    issue_req(0, 1, 3'b011);
    for (int k = 0; k < 10 && !tx_wr; k++) @(negedge clk);
    chk("ar2_wr_seen", int'(tx_wr), 1);
    #1 reset = 1'b0;
    #1;
    chk("ar2_tx_wr", int'(tx_wr), 0);
    chk("ar2_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Random commands against the keyboard model.
    for (int t = 0; t < 40; t++) begin
      bit is_rst, do_led;
      logic [2:0] v;
      int nr;
      is_rst = ($urandom_range(0, 3) == 0);
      do_led = !is_rst || ($urandom_range(0, 1) == 1);
      v = 3'($urandom);
      nr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      reply_q.delete();
      for (int i = 0; i < nr; i++) reply_q.push_back(pick_reply());
      model(is_rst, v);
      start_txn();
      issue_req(is_rst, do_led, v);
      feed_replies(1);
      compare($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
